// File: rtl/sad_ab_mem.sv
// sad_ab_mem: pixel-block memory and host front end for the SAD engine.
// Loads block A then block B from a host pixel stream, launches the SAD
// controller with a one-cycle go pulse, and answers AB_rd read strobes with
// registered A/B pixel pairs. Loaded data is retained across runs until clear.
module sad_ab_mem #(
  parameter int DW    = 8,    // pixel width
  parameter int DEPTH = 256,  // pixels per block
  parameter int AW    = 8     // address width, 2**AW must equal DEPTH
) (
  input  logic          clk,
  input  logic          rst,         // synchronous, active-low
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          start,
  input  logic          clear,
  output logic          loaded,
  output logic          busy,
  output logic          go,
  input  logic          sad_reg_ld,
  input  logic          AB_rd,
  input  logic [AW-1:0] i,
  output logic [DW-1:0] a_data,
  output logic [DW-1:0] b_data,
  output logic          rd_valid,
  output logic          rd_err
);

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_BUSY   = 2'd3;

  // Write counter value of the last pixel in a block.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          go_q, go_d;
  logic          rd_err_q, rd_err_d;
  logic          wr_ready_q, busy_q, loaded_q, rd_valid_q;
  logic [DW-1:0] a_data_q, b_data_q;
  logic          accept;
  logic          wr_en_a, wr_en_b;

  // A pixel transfers only when the registered ready flag is already high.
  assign accept = wr_valid & wr_ready_q;

  // Next-state logic for the load/ready/busy sequencer and the error flag.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    go_d     = 1'b0;
    rd_err_d = rd_err_q;
    wr_en_a  = 1'b0;
    wr_en_b  = 1'b0;

    case (state_q)
      S_LOAD_A: begin
        if (accept) begin
          wr_en_a = rst;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_ADDR) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          wr_en_b = rst;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_ADDR) state_d = S_READY;
        end
      end
      S_READY: begin
        // clear outranks start: discarding the blocks cancels any launch.
        if (clear) begin
          state_d  = S_LOAD_A;
          wcnt_d   = '0;
          rd_err_d = 1'b0;
        end else if (start) begin
          go_d    = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (sad_reg_ld) state_d = S_READY;
      end
      default: state_d = S_LOAD_A;
    endcase

    // A read strobe outside a run is a controller protocol error.
    if (AB_rd && (state_q != S_BUSY)) rd_err_d = 1'b1;
  end

  // Sequencer state and registered outputs, decoded from the next state so
  // each output is a flop with no logic after it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LOAD_A;
      wcnt_q     <= '0;
      go_q       <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      go_q       <= go_d;
      rd_err_q   <= rd_err_d;
      wr_ready_q <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      busy_q     <= (state_d == S_BUSY);
      loaded_q   <= (state_d == S_READY) || (state_d == S_BUSY);
      rd_valid_q <= AB_rd;
      if (AB_rd) begin
        a_data_q <= mem_a[i];
        b_data_q <= mem_b[i];
      end
    end
  end

  // Pixel storage writes.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; their contents are invalid
    // after reset anyway and resetting them would prevent RAM inference.
    if (wr_en_a) mem_a[wcnt_q] <= wr_data;
    if (wr_en_b) mem_b[wcnt_q] <= wr_data;
  end

  assign wr_ready = wr_ready_q;
  assign loaded   = loaded_q;
  assign busy     = busy_q;
  assign go       = go_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign a_data   = a_data_q;
  assign b_data   = b_data_q;

endmodule
